// File: rtl/spi_eeprom_sequencer.sv
// Wishbone master that sequences a 25LC020A EEPROM through the SPI
// controller's data/control registers: WREN, page write + WIP poll, read.
module spi_eeprom_sequencer #(
  parameter logic [31:0] DATA_ADDR  = 32'h0000_0010,
  parameter logic [31:0] CTRL_ADDR  = 32'h0000_0020,
  parameter logic [31:0] CTRL_SEL   = 32'hFFFF_FEFF,
  parameter logic [31:0] CTRL_CLR   = 32'hFFFF_FFFF,
  parameter logic [31:0] CTRL_DESEL = 32'hFFFF_F7FF,
  parameter int          SS_GAP     = 8,
  parameter int          IRQ_MAX    = 4096,
  parameter int          WIP_MAX    = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_dout,
  input  logic [31:0] wb_din,
  output logic        wb_we,
  output logic        wb_stb,
  output logic        wb_cyc,
  input  logic        wb_ack
);

  localparam int GW = $clog2(SS_GAP + 1);
  localparam int PW = $clog2(IRQ_MAX + 1);
  localparam int WW = $clog2(WIP_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_TXWAIT, S_WRDATA, S_POLL, S_RDDATA,
    S_CLR, S_DESEL, S_GAP, S_DONE, S_ABORT
  } state_t;

  typedef enum logic [1:0] {
    F_WREN, F_PROG, F_RDSR, F_READ
  } frame_t;

  state_t          r_state;
  state_t          w_state_n;
  frame_t          r_frame;
  logic            r_act;
  logic [4:0]      r_idx;
  logic [7:0]      r_byte;
  logic [7:0]      r_addr;
  logic [3:0]      r_len;
  logic [PW-1:0]   r_pcnt;
  logic [GW-1:0]   r_gcnt;
  logic [WW-1:0]   r_wcnt;
  logic            r_wip;
  logic            r_err;
  logic [7:0]      r_rx;
  logic            r_rxv;

  logic            w_ack;
  logic            w_acc;
  logic            w_last;
  logic            w_gap_end;
  logic [4:0]      w_nidx;
  logic [4:0]      w_last_idx;
  logic [7:0]      w_nbyte;
  logic            w_unused;

  assign w_ack     = r_act & wb_ack;
  assign w_last    = (r_idx == w_last_idx);
  assign w_gap_end = (r_gcnt == GW'(SS_GAP - 1));
  assign w_nidx    = (r_state == S_SEL) ? 5'd0 : r_idx + 5'd1;
  assign w_unused  = &{1'b0, wb_din[31:10], wb_din[8]};

  assign wb_stb   = r_act;
  assign wb_cyc   = r_act;
  assign rx_data  = r_rx;
  assign rx_valid = r_rxv;

  always_comb begin
    w_last_idx = 5'd0;
    unique case (r_frame)
      F_WREN:  w_last_idx = 5'd0;
      F_RDSR:  w_last_idx = 5'd1;
      default: w_last_idx = {1'b0, r_len} + 5'd2;
    endcase
  end

  always_comb begin
    w_nbyte = 8'h00;
    unique case (r_frame)
      F_WREN: w_nbyte = 8'h06;
      F_PROG: w_nbyte = (w_nidx == 5'd0) ? 8'h02 : r_addr;
      F_RDSR: w_nbyte = (w_nidx == 5'd0) ? 8'h05 : 8'h00;
      F_READ: w_nbyte = (w_nidx == 5'd0) ? 8'h03 :
                        (w_nidx == 5'd1) ? r_addr : 8'h00;
      default: w_nbyte = 8'h00;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    cmd_ready = 1'b0;
    tx_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    wb_addr   = 32'h0;
    wb_dout   = 32'h0;
    wb_we     = 1'b0;
    w_acc     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_n = S_SEL;
      end
      S_SEL: begin
        w_acc   = 1'b1;
        wb_addr = CTRL_ADDR;
        wb_dout = CTRL_SEL;
        wb_we   = 1'b1;
        if (w_ack) w_state_n = S_WRDATA;
      end
      S_TXWAIT: begin
        if (tx_valid) begin
          tx_ready  = 1'b1;
          w_state_n = S_WRDATA;
        end
      end
      S_WRDATA: begin
        w_acc   = 1'b1;
        wb_addr = DATA_ADDR;
        wb_dout = {24'h0, r_byte};
        wb_we   = 1'b1;
        if (w_ack) w_state_n = S_POLL;
      end
      S_POLL: begin
        w_acc   = 1'b1;
        wb_addr = CTRL_ADDR;
        if (w_ack) begin
          if (wb_din[9])
            w_state_n = S_RDDATA;
          else if (r_pcnt == PW'(IRQ_MAX))
            w_state_n = S_ABORT;
        end
      end
      S_RDDATA: begin
        w_acc   = 1'b1;
        wb_addr = DATA_ADDR;
        if (w_ack) w_state_n = w_last ? S_DESEL : S_CLR;
      end
      S_CLR: begin
        w_acc   = 1'b1;
        wb_addr = CTRL_ADDR;
        wb_dout = CTRL_CLR;
        wb_we   = 1'b1;
        if (w_ack)
          w_state_n = (r_frame == F_PROG && w_nidx >= 5'd2) ?
                      S_TXWAIT : S_WRDATA;
      end
      S_DESEL: begin
        w_acc   = 1'b1;
        wb_addr = CTRL_ADDR;
        wb_dout = CTRL_DESEL;
        wb_we   = 1'b1;
        if (w_ack) w_state_n = S_GAP;
      end
      S_GAP: begin
        if (w_gap_end) begin
          unique case (r_frame)
            F_WREN, F_PROG: w_state_n = S_SEL;
            F_RDSR: begin
              if (!r_wip)
                w_state_n = S_DONE;
              else if (r_wcnt == WW'(WIP_MAX))
                w_state_n = S_ABORT;
              else
                w_state_n = S_SEL;
            end
            default: w_state_n = S_DONE;
          endcase
        end
      end
      S_ABORT: begin
        w_acc   = 1'b1;
        wb_addr = CTRL_ADDR;
        wb_dout = CTRL_DESEL;
        wb_we   = 1'b1;
        if (w_ack) w_state_n = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        err       = r_err;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_frame <= F_WREN;
      r_act   <= 1'b0;
      r_idx   <= 5'd0;
      r_byte  <= 8'h00;
      r_addr  <= 8'h00;
      r_len   <= 4'h0;
      r_pcnt  <= '0;
      r_gcnt  <= '0;
      r_wcnt  <= '0;
      r_wip   <= 1'b0;
      r_err   <= 1'b0;
      r_rx    <= 8'h00;
      r_rxv   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_rxv   <= 1'b0;
      // stb rises one cycle after entering an access state: bus idle gap
      if (w_ack)
        r_act <= 1'b0;
      else if (w_acc || (r_state == S_TXWAIT && tx_valid))
        r_act <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_len   <= cmd_len;
            r_frame <= cmd_write ? F_WREN : F_READ;
            r_err   <= 1'b0;
          end
        end
        S_SEL, S_CLR: begin
          if (w_ack) begin
            r_idx  <= w_nidx;
            r_byte <= w_nbyte;
          end
        end
        S_TXWAIT: begin
          if (tx_valid) r_byte <= tx_data;
        end
        S_WRDATA: begin
          if (w_ack) r_pcnt <= '0;
        end
        S_POLL: begin
          if (w_ack && !wb_din[9]) r_pcnt <= r_pcnt + PW'(1);
        end
        S_RDDATA: begin
          if (w_ack) begin
            if (r_frame == F_READ && r_idx >= 5'd2) begin
              r_rx  <= wb_din[7:0];
              r_rxv <= 1'b1;
            end
            if (r_frame == F_RDSR && r_idx == 5'd1)
              r_wip <= wb_din[0];
          end
        end
        S_DESEL: begin
          if (w_ack) r_gcnt <= '0;
        end
        S_GAP: begin
          r_gcnt <= r_gcnt + GW'(1);
          if (w_gap_end) begin
            unique case (r_frame)
              F_WREN: r_frame <= F_PROG;
              F_PROG: begin
                r_frame <= F_RDSR;
                r_wcnt  <= '0;
              end
              F_RDSR:  r_wcnt <= r_wcnt + WW'(1);
              default: ;
            endcase
          end
        end
        S_ABORT: begin
          if (w_ack) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_eeprom_sequencer.sv
// Directed bench: Wishbone SPI-controller stand-in with a 25LC020A
// behavioural model behind it; immediate assertions at each check.
module tb_spi_eeprom_sequencer;

  localparam logic [31:0] SEL   = 32'hFFFF_FEFF;
  localparam logic [31:0] DESEL = 32'hFFFF_F7FF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = 8'h0;
  logic [3:0]  cmd_len = 4'h0;
  logic [7:0]  tx_data = 8'h0;
  logic        tx_valid = 1'b0;
  logic [31:0] wb_din = 32'h0;
  logic        wb_ack = 1'b0;
  logic        cmd_ready, tx_ready, rx_valid, busy, done, err;
  logic        wb_we, wb_stb, wb_cyc;
  logic [7:0]  rx_data;
  logic [31:0] wb_addr, wb_dout;

  spi_eeprom_sequencer #(.IRQ_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .err(err),
    .wb_addr(wb_addr), .wb_dout(wb_dout), .wb_din(wb_din),
    .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [256];
  bit          ss_n = 1'b1, wel = 1'b0, irq = 1'b0, irq_armed = 1'b0;
  bit          irq_never = 1'b0, rand_ack = 1'b0;
  bit          prev_stb = 1'b0, prev_ack = 1'b0, pop_pend = 1'b0;
  int          bidx = 0, wip_left = 0, irq_wait = 0, ctrl_reads = 0;
  int          desel_wr = 0, data_wr_desel = 0, proto_err = 0;
  int          wcnt = 0, dly = 0, hold_n = 0, popped = 0;
  logic [7:0]  op = 8'h0, ea = 8'h0, rxb = 8'h0;
  logic [31:0] last_ctrl = 32'h0;
  logic [7:0]  pend_a[$], pend_d[$];
  logic [7:0]  txlog[$], rxlog[$], tx_q[$], exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [7:0] got[$],
                       input logic [7:0] e[$]);
    chk({tag, "_n"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", tag, i), got[i], e[i]);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    rxb = 8'hFF;
    if (bidx == 0) op = b;
    else if (op == 8'h05) begin
      rxb = {6'b0, wel, (wip_left != 0)};
      if (wip_left > 0) wip_left--;
    end else if (op == 8'h03 || op == 8'h02) begin
      if (bidx == 1) ea = b;
      else if (op == 8'h03) begin
        rxb = mem[ea];
        ea  = ea + 8'd1;
      end else begin
        pend_a.push_back(ea);
        pend_d.push_back(b);
        ea = {ea[7:4], ea[3:0] + 4'd1};
      end
    end
    bidx++;
  endtask

  task automatic end_frame();
    if (bidx > 0 && op == 8'h06) wel = 1'b1;
    if (bidx > 0 && op == 8'h02 && wel) begin
      foreach (pend_a[i]) mem[pend_a[i]] = pend_d[i];
      wip_left = 3;
      wel = 1'b0;
    end
    pend_a.delete();
    pend_d.delete();
    bidx = 0;
  endtask

  task automatic access();
    if (wb_we) begin
      if (wb_addr == 32'h20) begin
        last_ctrl = wb_dout;
        irq = 1'b0;
        irq_armed = 1'b0;
        if (wb_dout == SEL) begin
          ss_n = 1'b0;
          bidx = 0;
        end else if (wb_dout == DESEL) begin
          desel_wr++;
          if (!ss_n) end_frame();
          ss_n = 1'b1;
        end
      end else if (wb_addr == 32'h10) begin
        txlog.push_back(wb_dout[7:0]);
        if (ss_n) data_wr_desel++;
        spi_byte(wb_dout[7:0]);
        irq_armed = 1'b1;
        irq_wait = 2;
      end
    end else if (wb_addr == 32'h20) begin
      ctrl_reads++;
      if (irq_armed && !irq_never) begin
        if (irq_wait == 0) irq = 1'b1;
        else irq_wait--;
      end
      wb_din = {22'h0, irq, 9'h0};
    end else begin
      wb_din = {24'h0, rxb};
    end
  endtask

  // SPI controller + EEPROM stand-in
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    forever begin
      @(negedge clk);
      if (!rst) begin
        wb_ack = 1'b0; wcnt = 0; ss_n = 1'b1; bidx = 0;
        pend_a.delete(); pend_d.delete();
        irq = 1'b0; irq_armed = 1'b0; prev_stb = 1'b0; prev_ack = 1'b0;
      end else begin
        if (prev_ack && wb_stb) proto_err++;
        if (prev_stb && !wb_stb && !prev_ack) proto_err++;
        prev_stb = wb_stb;
        prev_ack = 1'b0;
        if (wb_ack) wb_ack = 1'b0;
        else if (wb_stb && wb_cyc) begin
          if (wcnt < dly) wcnt++;
          else begin
            access();
            wb_ack = 1'b1;
            prev_ack = 1'b1;
            wcnt = 0;
            dly = rand_ack ? int'($urandom_range(0, 5)) : 0;
          end
        end
      end
    end
  end

  // payload feeder
  initial forever begin
    @(negedge clk);
    if (pop_pend && tx_q.size() > 0) begin
      void'(tx_q.pop_front());
      popped++;
    end
    pop_pend = 1'b0;
    if (hold_n > 0 && popped == 1) begin
      hold_n--;
      tx_valid = 1'b0;
    end else begin
      tx_valid = (tx_q.size() > 0);
      tx_data  = tx_valid ? tx_q[0] : 8'h00;
    end
    #1 pop_pend = tx_valid && tx_ready;
  end

  initial forever begin
    @(negedge clk);
    if (rx_valid) rxlog.push_back(rx_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic run_cmd(input bit wr, input logic [7:0] a,
                         input logic [3:0] l);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output bit got, output bit ev);
    got = 1'b0;
    ev  = 1'b0;
    for (int i = 0; i < 6000 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        ev  = err;
      end
    end
  endtask

  initial begin
    bit got, ev;
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_stb", {wb_stb, wb_cyc, wb_we}, 0);
    chk("rst_done", {done, err, tx_ready, rx_valid}, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: page write of three bytes at 0x10
    tx_q = '{8'hF3, 8'h21, 8'h15};
    popped = 0;
    txlog.delete();
    run_cmd(1'b1, 8'h10, 4'd2);
    chk("t1_busy", busy, 1);
    chk("t1_ready_low", cmd_ready, 0);
    wait_done(got, ev);
    chk("t1_done", got, 1);
    chk("t1_err", ev, 0);
    chk("t1_busy_done", busy, 0);
    chk("t1_ready_lag", cmd_ready, 0);
    @(negedge clk);
    chk("t1_ready", cmd_ready, 1);
    exp_q = '{8'h06, 8'h02, 8'h10, 8'hF3, 8'h21, 8'h15, 8'h05, 8'h00,
              8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
    chk_q("t1_tx", txlog, exp_q);
    chk("t1_mem", {mem[8'h10], mem[8'h11], mem[8'h12]}, 32'hF32115);

    // 2: read back
    rxlog.delete();
    txlog.delete();
    run_cmd(1'b0, 8'h10, 4'd2);
    wait_done(got, ev);
    chk("t2_done", got, 1);
    chk("t2_err", ev, 0);
    exp_q = '{8'hF3, 8'h21, 8'h15};
    chk_q("t2_rx", rxlog, exp_q);
    exp_q = '{8'h03, 8'h10, 8'h00, 8'h00, 8'h00};
    chk_q("t2_tx", txlog, exp_q);
    chk("t2_ss", ss_n, 1);

    // 3: payload stalls before the second byte
    tx_q = '{8'h5A, 8'hA5, 8'h3C};
    popped = 0;
    hold_n = 500;
    txlog.delete();
    run_cmd(1'b1, 8'h20, 4'd2);
    for (int i = 0; i < 3000 && hold_n > 250; i++) @(negedge clk);
    chk("t3_mid_bytes", txlog.size(), 4);
    chk("t3_mid_ss", ss_n, 0);
    for (int i = 0; i < 3000 && hold_n > 1; i++) @(negedge clk);
    chk("t3_end_bytes", txlog.size(), 4);
    chk("t3_end_ss", ss_n, 0);
    chk("t3_end_stb", wb_stb, 0);
    wait_done(got, ev);
    chk("t3_done", got, 1);
    chk("t3_err", ev, 0);
    chk("t3_mem", {mem[8'h20], mem[8'h21], mem[8'h22]}, 32'h5AA53C);

    // 4: controller irq never raised
    irq_never = 1'b1;
    ctrl_reads = 0;
    desel_wr = 0;
    txlog.delete();
    run_cmd(1'b0, 8'h00, 4'd0);
    wait_done(got, ev);
    chk("t4_done", got, 1);
    chk("t4_err", ev, 1);
    chk("t4_polls", ctrl_reads, 17);
    chk("t4_desel", desel_wr, 1);
    chk("t4_last_ctrl", last_ctrl, DESEL);
    chk("t4_bytes", txlog.size(), 1);
    chk("t4_ss", ss_n, 1);
    irq_never = 1'b0;
    @(negedge clk);
    chk("t4_ready", cmd_ready, 1);

    // 5: reset during the address byte
    txlog.delete();
    run_cmd(1'b0, 8'h10, 4'd2);
    for (int i = 0; i < 3000 && txlog.size() < 2; i++) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_ready", cmd_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_bus", {wb_stb, wb_cyc, wb_we}, 0);
    chk("t5_addr", wb_addr, 0);
    chk("t5_pulses", {done, err, rx_valid, tx_ready}, 0);
    @(negedge clk);
    rst = 1'b1;
    rxlog.delete();
    run_cmd(1'b0, 8'h10, 4'd2);
    wait_done(got, ev);
    chk("t5_done", got, 1);
    chk("t5_err", ev, 0);
    exp_q = '{8'hF3, 8'h21, 8'h15};
    chk_q("t5_rx", rxlog, exp_q);

    // 6: random ack latency, write + read, plus length extremes
    rand_ack = 1'b1;
    tx_q = '{8'hF3, 8'h21, 8'h15};
    popped = 0;
    txlog.delete();
    run_cmd(1'b1, 8'h40, 4'd2);
    wait_done(got, ev);
    chk("t6_done", got, 1);
    chk("t6_err", ev, 0);
    exp_q = '{8'h06, 8'h02, 8'h40, 8'hF3, 8'h21, 8'h15, 8'h05, 8'h00,
              8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
    chk_q("t6_tx", txlog, exp_q);
    chk("t6_mem", {mem[8'h40], mem[8'h41], mem[8'h42]}, 32'hF32115);
    rxlog.delete();
    run_cmd(1'b0, 8'h40, 4'd2);
    wait_done(got, ev);
    chk("t6_rdone", got, 1);
    exp_q = '{8'hF3, 8'h21, 8'h15};
    chk_q("t6_rx", rxlog, exp_q);
    rxlog.delete();
    run_cmd(1'b0, 8'h11, 4'd0);
    wait_done(got, ev);
    chk("t6_len0_done", got, 1);
    exp_q = '{8'h21};
    chk_q("t6_len0", rxlog, exp_q);
    rxlog.delete();
    run_cmd(1'b0, 8'h30, 4'd15);
    wait_done(got, ev);
    chk("t6_len15_done", got, 1);
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
              8'h38, 8'h39, 8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3E, 8'h3F};
    chk_q("t6_len15", rxlog, exp_q);
    n = proto_err;
    chk("bus_protocol", n, 0);
    chk("data_wr_deselected", data_wr_desel, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
